// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmitter arbiter.
package uart_arb_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_DONE
  } arb_state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin pick: first set request bit at or above ptr, wrapping modulo N_REQ.
module rr_priority_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic                     found,
  output logic [$clog2(N_REQ)-1:0] idx
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int POS_W = $clog2(2 * N_REQ);

  logic [N_REQ-1:0]   below;
  logic [2*N_REQ-1:0] dbl;
  logic [POS_W-1:0]   pos;

  // Lower copy masks requesters below ptr; upper copy supplies the wrapped ones.
  always_comb begin
    below = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      below[i] = (IDX_W'(i) < ptr);
    end
    dbl   = {req, req & ~below};
    found = 1'b0;
    pos   = '0;
    for (int unsigned i = 0; i < 2 * N_REQ; i++) begin
      if (!found && dbl[i]) begin
        found = 1'b1;
        pos   = POS_W'(i);
      end
    end
    if (pos >= POS_W'(N_REQ)) begin
      idx = IDX_W'(pos - POS_W'(N_REQ));
    end else begin
      idx = IDX_W'(pos);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one serial transmitter among N_REQ byte sources,
// with a send-handshake timeout that aborts a transfer the transmitter never accepts.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int SEND_TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [N_REQ-1:0]             req,
  input  logic [N_REQ-1:0][DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]             ack,
  output logic                         tx_send,
  output logic [DATA_W-1:0]            tx_data,
  input  logic                         tx_rdy,
  output logic                         busy,
  output logic [$clog2(N_REQ)-1:0]     grant_idx,
  output logic                         err
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(SEND_TIMEOUT) + 1;

  arb_state_t       state;
  logic [IDX_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] next_ptr;

  rr_priority_pick #(
    .N_REQ(N_REQ)
  ) u_pick (
    .req  (req),
    .ptr  (ptr),
    .found(pick_found),
    .idx  (pick_idx)
  );

  always_comb begin
    next_ptr = grant_idx + 1'b1;
    if (grant_idx == IDX_W'(N_REQ - 1)) begin
      next_ptr = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ptr       <= '0;
      grant_idx <= '0;
      tx_data   <= '0;
      tx_send   <= 1'b0;
      ack       <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
      cnt       <= '0;
    end else begin
      ack <= '0;
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_rdy && pick_found) begin
            state     <= SEND;
            tx_send   <= 1'b1;
            busy      <= 1'b1;
            tx_data   <= req_data[pick_idx];
            grant_idx <= pick_idx;
            cnt       <= '0;
          end
        end
        SEND: begin
          if (!tx_rdy) begin
            state   <= WAIT_DONE;
            tx_send <= 1'b0;
            cnt     <= '0;
          end else if (cnt == CNT_W'(SEND_TIMEOUT - 1)) begin
            // Abort: advance past the stuck winner so the others still get served.
            state   <= IDLE;
            tx_send <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b1;
            ptr     <= next_ptr;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (tx_rdy) begin
            state          <= IDLE;
            busy           <= 1'b0;
            ack[grant_idx] <= 1'b1;
            ptr            <= next_ptr;
          end
        end
        default: begin
          state   <= IDLE;
          tx_send <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares a single `rtl_transmitter` serial transmitter among `N_REQ` independent byte sources. It sits between the requesters and the transmitter. It latches one requester's byte, sequences the transmitter's `send`/`rdy` handshake, and returns a completion pulse to the requester. It also recovers from a transmitter that never acknowledges.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `SEND_TIMEOUT`, 16: maximum cycles `tx_send` is held waiting for `tx_rdy` to fall before the transfer is aborted.
- `clk` in 1: system clock, 100 MHz.
- `reset_n` in 1: reset, asynchronous, active-low.
- `req` in N_REQ: per-requester request level; held high with stable data until `ack` for that requester.
- `req_data` in N_REQ×8: per-requester byte, packed `[N_REQ-1:0][7:0]`.
- `ack` out N_REQ: one-hot, one-cycle pulse when the granted byte has finished transmitting.
- `tx_send` out 1: to transmitter `send`.
- `tx_data` out 8: to transmitter `data`; stable for the whole transfer.
- `tx_rdy` in 1: from transmitter `rdy`; high when idle.
- `busy` out 1: high in any state other than IDLE.
- `grant_idx` out $clog2(N_REQ): index of the current or last granted requester.
- `err` out 1: one-cycle pulse on a send timeout.

## Operation
- States:
  - IDLE: no transfer in progress.
  - SEND: `tx_send`=1; wait for `tx_rdy`=0.
  - WAIT_DONE: `tx_send`=0; wait for `tx_rdy`=1.
- IDLE → SEND: requires `tx_rdy`=1 and `|req`.
  - The winner is the first set bit of `req` scanning upward from `ptr`, wrapping modulo N_REQ.
  - On the transition, `tx_data` ← `req_data[winner]` and `grant_idx` ← winner.
- SEND → WAIT_DONE: on `tx_rdy`=0. The timeout counter clears.
- SEND → IDLE: when the counter reaches SEND_TIMEOUT−1 with `tx_rdy` still 1.
  - `err` pulses and no `ack` is issued.
  - `ptr` ← winner+1, so a dead requester cannot starve the others.
- WAIT_DONE → IDLE: on `tx_rdy`=1.
  - `ack[grant_idx]` pulses.
  - `ptr` ← (grant_idx+1) mod N_REQ.
- `tx_send` is never held across WAIT_DONE, so the transmitter cannot double-send.
- A requester dropping `req` mid-transfer is ignored: the transfer completes and `ack` still pulses.
- A requester changing `req_data` after grant has no effect, because the byte is latched at grant.
- Requests arriving while `busy` simply wait. There is no queueing beyond the held `req` levels.
- Reset values:
  - state=IDLE, `ptr`=0, `grant_idx`=0.
  - `tx_data`=8'h00, `tx_send`=0.
  - `ack`=0, `err`=0, `busy`=0.
  - Timeout counter=0.
- Reset asserted mid-transfer: all outputs go to reset values immediately (asynchronous). The aborted requester receives no `ack`.

## Timing
- All outputs are registered.
- Grant latency: `req` high in IDLE at edge k gives `tx_send`=1, `busy`=1, `tx_data` valid after edge k+1.
- `tx_rdy` falls with `tx_send`=1 (sampled at edge m): `tx_send`=0 after edge m+1.
- `tx_rdy` rises in WAIT_DONE (sampled at edge n): `ack` is high for exactly the cycle after edge n+1, and the state is IDLE at the same edge.
- Back-to-back transfers:
  - A new grant can occur on the edge after `ack` asserts, i.e. the edge following the IDLE entry.
  - So there is at least one IDLE cycle between transfers.
- The timeout counter has width $clog2(SEND_TIMEOUT)+1. It counts only in SEND and saturates nowhere because the abort happens at terminal count.
- Simultaneous `req` from all sources with `ptr`=2 and N_REQ=4 gives grant order 2,3,0,1.

## Structure
- Package `uart_arb_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE} arb_state_t;`
  - `localparam DATA_W = 8`.
- Sub-module `rr_priority_pick` is combinational and parameterized by N_REQ.
  - Inputs: `req`, `ptr`.
  - Outputs: `found`, `idx`.
  - Implementation: double-width masked priority encode.
- The arbiter FSM, data latch and timeout counter live in `uart_tx_arbiter`.

## Test plan
- Single requester:
  - Stimulus: `req`=4'b0001, `req_data[0]`=8'hA5; transmitter model drops `rdy` 2 cycles after `send` and raises it 1040 cycles later.
  - Required response: `tx_data`=8'hA5; one `ack[0]` pulse; `tx_send` high for exactly 3 cycles.
- Round-robin fairness:
  - Stimulus: `req`=4'b1111 held, data 8'h10..8'h13.
  - Required response: `tx_data` sequence 10,11,12,13,10; each `ack` one-hot and in the same order.
- Starvation check:
  - Stimulus: `req[0]` permanently high, `req[2]` high.
  - Required response: grants alternate 0,2,0,2.
- Timeout:
  - Stimulus: transmitter model holds `rdy`=1 and ignores `send`.
  - Required response: `err` pulse 16 cycles after `tx_send` rises; no `ack`; next pending requester granted afterward.
- Request withdrawal and data change:
  - Stimulus: `req[1]` dropped and `req_data[1]` changed to 8'hFF in WAIT_DONE.
  - Required response: original byte still transmitted; `ack[1]` still pulses.
- Reset mid-transfer:
  - Stimulus: `reset_n` low during SEND.
  - Required response: `tx_send`=0, `busy`=0, `ptr`=0 without a clock edge; after release, requester 0 is granted first.
